// File: rtl/pid_pkg.sv
// Shared types and constants for the pid core sequencer: host register map,
// gain count and the sequencing FSM state encoding.
package pid_pkg;

  localparam int NUM_GAINS  = 4;
  localparam int GAIN_IDX_W = $clog2(NUM_GAINS);

  typedef logic [GAIN_IDX_W-1:0] gain_idx_t;

  localparam logic [2:0] ADDR_KP     = 3'd0;
  localparam logic [2:0] ADDR_KI     = 3'd1;
  localparam logic [2:0] ADDR_KD1    = 3'd2;
  localparam logic [2:0] ADDR_KD2    = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_MEAS,
    ITERATE,
    CAPTURE
  } seq_state_t;

endpackage

// File: rtl/pid_tick_gen.sv
// Sample-rate tick generator: free-running counter over a host-programmable
// period; a new period is staged and only becomes active on a counter wrap.
module pid_tick_gen #(
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                period_wr,
  input  logic [PERIOD_W-1:0] period_data,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE          = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(DEFAULT_PERIOD);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] pending_q;
  logic [PERIOD_W-1:0] last_count;

  // A period of 0 behaves as 1: the counter wraps every cycle.
  always_comb begin
    last_count = (period_q == '0) ? '0 : period_q - ONE;
    tick       = enable && (count_q == last_count);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      period_q  <= RESET_PERIOD;
      pending_q <= RESET_PERIOD;
    end else begin
      if (period_wr) pending_q <= period_data;

      if (!enable) begin
        count_q  <= '0;
        period_q <= pending_q;
      end else if (tick) begin
        count_q  <= '0;
        period_q <= pending_q;
      end else begin
        count_q  <= count_q + ONE;
      end
    end
  end

endmodule

// File: rtl/pid_sequencer.sv
// Paces one pid core: per sample tick optionally reloads the four gains as an
// atomic set, fetches one measurement, strobes iterate and captures the result.
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               host_wr_valid,
  input  logic [2:0]         host_wr_addr,
  input  logic [D_WIDTH-1:0] host_wr_data,
  input  logic               host_commit,
  input  logic [D_WIDTH-1:0] target,
  input  logic               meas_valid,
  input  logic [D_WIDTH-1:0] meas_data,
  output logic               meas_ready,
  output logic               pid_write_n,
  output logic [D_WIDTH-1:0] pid_reg_addr,
  output logic [D_WIDTH-1:0] pid_reg_data,
  output logic               pid_iterate,
  output logic [D_WIDTH-1:0] pid_target,
  output logic [D_WIDTH-1:0] pid_measurement,
  input  logic [D_WIDTH-1:0] pid_out,
  output logic               ctrl_valid,
  output logic [D_WIDTH-1:0] ctrl_data,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam gain_idx_t LAST_IDX = gain_idx_t'(NUM_GAINS - 1);

  seq_state_t         state_q, state_d;
  gain_idx_t          load_idx_q;
  logic               commit_pending_q;
  logic [D_WIDTH-1:0] shadow_q  [NUM_GAINS];
  logic [D_WIDTH-1:0] staging_q [NUM_GAINS];
  logic [D_WIDTH-1:0] meas_q;
  logic [D_WIDTH-1:0] ctrl_data_q;
  logic               ctrl_valid_q;
  logic               overrun_q;
  logic               tick;
  logic               period_wr;
  logic               load_start;
  logic               accept;

  assign period_wr = host_wr_valid && (host_wr_addr == ADDR_PERIOD);

  pid_tick_gen #(
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_tick_gen (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .period_wr   (period_wr),
    .period_data (host_wr_data[PERIOD_W-1:0]),
    .tick        (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d         = state_q;
    load_start      = 1'b0;
    meas_ready      = 1'b0;
    pid_write_n     = 1'b1;
    pid_reg_addr    = '0;
    pid_reg_data    = '0;
    pid_iterate     = 1'b0;
    pid_target      = '0;
    pid_measurement = '0;
    unique case (state_q)
      IDLE: begin
        // A commit arriving with the tick still counts for this tick.
        if (tick) begin
          if (commit_pending_q || host_commit) begin
            state_d    = LOAD;
            load_start = 1'b1;
          end else begin
            state_d    = WAIT_MEAS;
          end
        end
      end
      LOAD: begin
        pid_write_n  = 1'b0;
        pid_reg_addr = D_WIDTH'(load_idx_q);
        pid_reg_data = staging_q[load_idx_q];
        if (load_idx_q == LAST_IDX) state_d = WAIT_MEAS;
      end
      WAIT_MEAS: begin
        meas_ready = 1'b1;
        if (meas_valid) state_d = ITERATE;
      end
      ITERATE: begin
        pid_iterate     = 1'b1;
        pid_target      = target;
        pid_measurement = meas_q;
        state_d         = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    accept = meas_ready && meas_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_idx_q       <= '0;
      commit_pending_q <= 1'b1;
      ctrl_data_q      <= '0;
      ctrl_valid_q     <= 1'b0;
      overrun_q        <= 1'b0;
      for (int i = 0; i < NUM_GAINS; i++) shadow_q[i] <= '0;
    end else begin
      load_idx_q   <= (state_q == LOAD) ? load_idx_q + gain_idx_t'(1) : '0;
      ctrl_valid_q <= (state_q == CAPTURE);
      if (state_q == CAPTURE) ctrl_data_q <= pid_out;

      if (load_start)       commit_pending_q <= 1'b0;
      else if (host_commit) commit_pending_q <= 1'b1;

      if (overrun_clr)                       overrun_q <= 1'b0;
      else if (tick && (state_q != IDLE))    overrun_q <= 1'b1;

      if (host_wr_valid) begin
        case (host_wr_addr)
          ADDR_KP:  shadow_q[0] <= host_wr_data;
          ADDR_KI:  shadow_q[1] <= host_wr_data;
          ADDR_KD1: shadow_q[2] <= host_wr_data;
          ADDR_KD2: shadow_q[3] <= host_wr_data;
          default: ;
        endcase
      end
    end
  end

  // NOTE: staging and sample registers carry no reset; they are only observed in
  // LOAD / ITERATE, which are always preceded by the write that fills them.
  always_ff @(posedge clock) begin
    if (load_start) staging_q <= shadow_q;
    if (accept)     meas_q    <= meas_data;
  end

  assign ctrl_valid = ctrl_valid_q;
  assign ctrl_data  = ctrl_data_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench for pid_sequencer: scoreboards for gain writes and control
// outputs, plus a toy registered core driving pid_out.
module tb_pid_sequencer;

  localparam int DW  = 32;
  localparam int PW  = 16;
  localparam int DEF = 8;

  localparam logic [2:0] A_KP = 3'd0, A_KI = 3'd1, A_KD1 = 3'd2, A_PERIOD = 3'd4;

  typedef struct { logic [DW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] data; int cyc; } ctrl_exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          host_wr_valid = 1'b0;
  logic [2:0]    host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_commit = 1'b0;
  logic [DW-1:0] target = '0;
  logic          meas_valid = 1'b0;
  logic [DW-1:0] meas_data = '0;
  logic          meas_ready;
  logic          pid_write_n;
  logic [DW-1:0] pid_reg_addr, pid_reg_data;
  logic          pid_iterate;
  logic [DW-1:0] pid_target, pid_measurement;
  logic [DW-1:0] pid_out = '0;
  logic          ctrl_valid;
  logic [DW-1:0] ctrl_data;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int iters = 0;
  int writes_seen = 0;

  logic [DW-1:0] sh [4];
  logic [DW-1:0] consumed_meas = '0;
  wr_t           wr_q[$];
  ctrl_exp_t     ctrl_q[$];

  pid_sequencer #(.D_WIDTH(DW), .PERIOD_W(PW), .DEFAULT_PERIOD(DEF)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_commit(host_commit), .target(target),
    .meas_valid(meas_valid), .meas_data(meas_data), .meas_ready(meas_ready),
    .pid_write_n(pid_write_n), .pid_reg_addr(pid_reg_addr), .pid_reg_data(pid_reg_data),
    .pid_iterate(pid_iterate), .pid_target(pid_target), .pid_measurement(pid_measurement),
    .pid_out(pid_out), .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] core_f(input logic [DW-1:0] t, input logic [DW-1:0] m);
    return t ^ {m[15:0], m[31:16]};
  endfunction

  // Toy core: registered output computed from the iterate-cycle inputs.
  always @(posedge clock) if (pid_iterate) pid_out <= core_f(pid_target, pid_measurement);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Measurement source: on each handshake, predict the control output and present a new sample.
  always @(negedge clock) begin : drv
    logic [DW-1:0] next_target;
    if (!reset && meas_valid && meas_ready) begin
      next_target   = $urandom;
      consumed_meas = meas_data;
      ctrl_q.push_back('{data: core_f(next_target, meas_data), cyc: cyc});
      @(posedge clock);
      #1;
      target    = next_target;
      meas_data = $urandom;
    end
  end

  always @(negedge clock) begin : mon
    wr_t       w;
    ctrl_exp_t e;
    if (!reset) begin
      if (!pid_write_n) begin
        writes_seen++;
        if (wr_q.size() == 0) check("write_unexpected", 1, 0);
        else begin
          w = wr_q.pop_front();
          check("write_addr", pid_reg_addr, w.addr);
          check("write_data", pid_reg_data, w.data);
        end
      end
      if (pid_iterate) begin
        iters++;
        check("iter_target", pid_target, target);
        check("iter_meas", pid_measurement, consumed_meas);
      end
      if (ctrl_valid) begin
        if (ctrl_q.size() == 0) check("ctrl_unexpected", 1, 0);
        else begin
          e = ctrl_q.pop_front();
          check("ctrl_data", ctrl_data, e.data);
          check("ctrl_latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  task automatic push_load();
    for (int i = 0; i < 4; i++) wr_q.push_back('{addr: DW'(i), data: sh[i]});
  endtask

  task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
    host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d;
    if (a < 3'd4) sh[a[1:0]] = d;
    @(posedge clock); #1;
    host_wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    host_commit = 1'b1;
    @(posedge clock); #1;
    host_commit = 1'b0;
  endtask

  task automatic wait_ctrl(output int c);
    bit seen;
    seen = 1'b0; c = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock);
      if (ctrl_valid === 1'b1) begin seen = 1'b1; c = cyc; end
    end
    if (!seen) check("ctrl_timeout", 0, 1);
  endtask

  task automatic wait_write();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock);
      if (pid_write_n === 1'b0) seen = 1'b1;
    end
    if (!seen) check("load_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock);
      if (meas_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && wr_q.size() != 0; k++) @(negedge clock);
    check(tag, wr_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3, w0, it0;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    target    = $urandom;
    meas_data = $urandom;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_write_n", pid_write_n, 1);
    check("rst_meas_ready", meas_ready, 0);
    check("rst_iterate", pid_iterate, 0);
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_ctrl_data", ctrl_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_reg_addr", pid_reg_addr, 0);
    check("rst_reg_data", pid_reg_data, 0);
    check("rst_pid_target", pid_target, 0);
    check("rst_pid_meas", pid_measurement, 0);
    push_load();
    @(posedge clock); #1;
    reset = 1'b0; enable = 1'b1; meas_valid = 1'b1;

    // 1: first tick loads zero gains, then one sample
    wait_ctrl(c0);
    @(negedge clock);
    check("t1_ctrl_one_cycle", ctrl_valid, 0);
    check("t1_writes", writes_seen, 4);
    check("t1_queue_empty", wr_q.size(), 0);

    // 2: kp set, one burst, following tick has no LOAD
    host_write(A_KP, 32'h8000);
    push_load();
    do_commit();
    wait_drain("t2_drain");
    wait_ctrl(c0);
    w0 = writes_seen;
    wait_ctrl(c0);
    check("t2_no_reload", writes_seen, w0);
    check("t2_no_overrun", overrun, 0);

    // 3: starved measurement -> stuck in WAIT_MEAS, overrun; clear; one iterate
    @(posedge clock); #1;
    meas_valid = 1'b0;
    wait_ready();
    it0 = iters;
    repeat (20) @(negedge clock);
    check("t3_still_waiting", meas_ready, 1);
    check("t3_overrun_set", overrun, 1);
    check("t3_no_iterate", iters, it0);
    @(posedge clock); #1; overrun_clr = 1'b1;
    @(posedge clock); #1; overrun_clr = 1'b0;
    @(negedge clock);
    check("t3_overrun_clr", overrun, 0);
    @(posedge clock); #1;
    meas_valid = 1'b1;
    wait_ctrl(c0);
    check("t3_one_iterate", iters, it0 + 1);

    // 4: ki=5 committed, ki=7 written and committed mid-LOAD
    host_write(A_KI, 32'd5);
    push_load();
    do_commit();
    wait_write();
    @(posedge clock); #1;
    host_write(A_KI, 32'd7);
    push_load();
    do_commit();
    wait_drain("t4_drain");
    wait_ctrl(c0);
    w0 = writes_seen;
    wait_ctrl(c0);
    check("t4_no_third_load", writes_seen, w0);

    // 5: period=3 written mid-count applies after current wrap; then period=0
    wait_ctrl(c1);
    host_write(A_PERIOD, 32'd3);
    wait_ctrl(c2);
    check("t5_old_period", c2 - c1, 8);
    wait_ctrl(c3);
    check("t5_period3_spacing", c3 - c2, 6);
    host_write(A_PERIOD, 32'd0);
    repeat (3) wait_ctrl(c0);
    wait_ctrl(c1);
    wait_ctrl(c2);
    check("t5_period0_spacing", c2 - c1, 4);
    check("t5_overrun", overrun, 1);

    // enable dropped mid-sequence: sequence completes, then silence
    wait_ctrl(c1);
    @(posedge clock); #1;
    enable = 1'b0;
    wait_ctrl(c2);
    check("en_off_completes", c2 - c1, 4);
    it0 = iters;
    repeat (20) @(negedge clock);
    check("en_off_no_iter", iters, it0);
    check("en_off_idle", meas_ready, 0);

    // 6: reset during LOAD cycle 2, then full zero reload
    @(posedge clock); #1;
    enable = 1'b1;
    host_write(A_KD1, 32'h33);
    push_load();
    do_commit();
    wait_write();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    wr_q.delete();
    ctrl_q.delete();
    for (int i = 0; i < 4; i++) sh[i] = '0;
    push_load();
    @(negedge clock);
    check("t6_write_n_high", pid_write_n, 1);
    check("t6_meas_ready", meas_ready, 0);
    check("t6_overrun", overrun, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    w0 = writes_seen;
    wait_drain("t6_drain");
    wait_ctrl(c0);
    check("t6_full_reload", writes_seen - w0, 4);
    wait_ctrl(c0);
    check("t6_single_reload", writes_seen - w0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
